// File: rtl/fifo_drain_unpacker.sv
// fifo_drain_unpacker: pops wide FIFO words and streams them LSB slice first on a valid/ready port
module fifo_drain_unpacker #(
  parameter int DATA_WIDTH  = 32,
  parameter int OUT_WIDTH   = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_dout,
  output logic                   fifo_cs,
  output logic                   fifo_rd_en,
  output logic [OUT_WIDTH-1:0]   m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] word_count
);
  localparam int SLICES = DATA_WIDTH / OUT_WIDTH;
  localparam int IDX_W  = SLICES > 1 ? $clog2(SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

  generate
    if (DATA_WIDTH % OUT_WIDTH != 0) begin : g_bad_width
      $error("fifo_drain_unpacker: DATA_WIDTH must be a multiple of OUT_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RD, WAIT, SEND} state_t;

  state_t                 r_state, w_next;
  logic                   r_rd_en, r_valid;
  logic [DATA_WIDTH-1:0]  r_shift;
  logic [IDX_W-1:0]       r_idx;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   w_pop_ok, w_accept, w_last;

  assign w_pop_ok   = enable && !fifo_empty;
  assign w_accept   = r_valid && m_ready;
  assign w_last     = r_idx == LAST_IDX;
  assign fifo_rd_en = r_rd_en;
  assign fifo_cs    = r_rd_en;
  assign m_data     = r_shift[OUT_WIDTH-1:0];
  assign m_valid    = r_valid;
  assign m_last     = r_valid && w_last;
  assign busy       = r_state != IDLE;
  assign word_count = r_count;

  // next state: a pop is only decided in IDLE or on acceptance of a word's last slice
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_pop_ok ? RD : IDLE;
      RD:      w_next = WAIT;
      WAIT:    w_next = SEND;
      SEND:    w_next = (w_accept && w_last) ? (w_pop_ok ? RD : IDLE) : SEND;
      default: w_next = IDLE;
    endcase
  end

  // state, pop strobe, shift register, slice index and completed-word counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rd_en <= 1'b0;
      r_valid <= 1'b0;
      r_shift <= '0;
      r_idx   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_rd_en <= w_next == RD;
      if (r_state == WAIT) begin
        r_shift <= fifo_dout;
        r_valid <= 1'b1;
        r_idx   <= '0;
      end else if (w_accept) begin
        r_shift <= r_shift >> OUT_WIDTH;
        r_idx   <= r_idx + IDX_W'(1);
        if (w_last) begin
          r_valid <= 1'b0;
          r_count <= r_count + COUNT_WIDTH'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_fifo_drain_unpacker.sv
// tb_fifo_drain_unpacker: scoreboard bench with a behavioural FIFO feeding the unpacker
module tb_fifo_drain_unpacker;
  logic        clk = 1'b0, rst = 1'b1, enable = 1'b1, m_ready = 1'b1;
  logic        fifo_empty, fifo_cs, fifo_rd_en, m_valid, m_last, busy;
  logic [31:0] fifo_dout = '0;
  logic [7:0]  m_data;
  logic [15:0] word_count;

  always #5 clk = ~clk;

  fifo_drain_unpacker #(.DATA_WIDTH(32), .OUT_WIDTH(8), .COUNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_cs(fifo_cs), .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .word_count(word_count)
  );

  logic [31:0] mem [0:63];
  int f_wr = 0, f_rd = 0, pops = 0, cyc = 0;
  bit uflow = 1'b0;
  int pop_cyc[$];

  assign fifo_empty = f_wr == f_rd;

  // synchronous FIFO model: data appears the cycle after the pop edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en && fifo_cs) begin
      if (f_wr == f_rd) uflow <= 1'b1;
      fifo_dout <= mem[f_rd % 64];
      f_rd <= f_rd + 1;
      pops <= pops + 1;
      pop_cyc.push_back(cyc);
    end
  end

  logic [8:0]  exp_q[$];
  string       dq_n[$];
  logic [31:0] dq_a[$], dq_e[$];
  int n_cmp = 0, n_err = 0;

  // monitor: drains posted point checks and compares every accepted slice against the scoreboard
  always @(negedge clk) begin
    string nm;
    logic [31:0] a, e;
    logic [8:0] x;
    while (dq_n.size() > 0) begin
      nm = dq_n.pop_front();
      a = dq_a.pop_front();
      e = dq_e.pop_front();
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
    end
    if (!rst && m_valid && m_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL slice: got last=%b data=%h expected no slice", m_last, m_data);
      end else begin
        x = exp_q.pop_front();
        if ({m_last, m_data} !== x) begin
          n_err++;
          $display("FAIL slice: got last=%b data=%h expected last=%b data=%h", m_last, m_data, x[8], x[7:0]);
        end
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    dq_n.push_back(nm);
    dq_a.push_back(a);
    dq_e.push_back(e);
  endtask

  task automatic push_word(logic [31:0] w);
    mem[f_wr % 64] = w;
    f_wr++;
  endtask

  task automatic expect_word(logic [31:0] w);
    for (int k = 0; k < 4; k++) exp_q.push_back({1'(k == 3), w[8*k +: 8]});
  endtask

  task automatic wait_drain(string nm);
    for (int i = 0; i < 200 && (busy || exp_q.size() != 0); i++) tick();
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int p0;
    push_word(32'h44332211);
    repeat (3) begin
      tick();
      chk("rst_rd_en", 32'(fifo_rd_en), 0);
      chk("rst_cs", 32'(fifo_cs), 0);
      chk("rst_valid", 32'(m_valid), 0);
      chk("rst_last", 32'(m_last), 0);
      chk("rst_data", 32'(m_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_count", 32'(word_count), 0);
    end
    chk("rst_pops", pops, 0);
    expect_word(32'h44332211);
    rst = 1'b0;
    tick();
    chk("e0_rd_en", 32'(fifo_rd_en), 1);
    chk("e0_cs", 32'(fifo_cs), 1);
    chk("e0_valid", 32'(m_valid), 0);
    chk("e0_busy", 32'(busy), 1);
    tick();
    chk("e1_rd_en", 32'(fifo_rd_en), 0);
    chk("e1_valid", 32'(m_valid), 0);
    tick();
    chk("e2_valid", 32'(m_valid), 1);
    chk("e2_data", 32'(m_data), 32'h11);
    chk("e2_last", 32'(m_last), 0);
    chk("e2_rd_en", 32'(fifo_rd_en), 0);
    tick(3);
    chk("e5_last", 32'(m_last), 1);
    chk("e5_data", 32'(m_data), 32'h44);
    tick();
    chk("e6_valid", 32'(m_valid), 0);
    chk("e6_busy", 32'(busy), 0);
    chk("e6_count", 32'(word_count), 1);
    chk("single_pops", pops, 1);

    push_word(32'h44332211);
    expect_word(32'h44332211);
    tick(4);
    chk("bp_pre_data", 32'(m_data), 32'h22);
    m_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("bp_hold_data", 32'(m_data), 32'h22);
      chk("bp_hold_valid", 32'(m_valid), 1);
      chk("bp_hold_last", 32'(m_last), 0);
    end
    m_ready = 1'b1;
    wait_drain("bp");
    chk("bp_count", 32'(word_count), 2);
    chk("bp_pops", pops, 2);

    p0 = pop_cyc.size();
    push_word(32'd1);
    push_word(32'd10);
    push_word(32'd100);
    expect_word(32'd1);
    expect_word(32'd10);
    expect_word(32'd100);
    wait_drain("b2b");
    chk("b2b_pops", pops, 5);
    chk("b2b_gap1", pop_cyc[p0+1] - pop_cyc[p0], 6);
    chk("b2b_gap2", pop_cyc[p0+2] - pop_cyc[p0+1], 6);
    chk("b2b_count", 32'(word_count), 5);
    chk("b2b_empty", 32'(fifo_empty), 1);
    tick(5);
    chk("b2b_no_extra_pop", pops, 5);

    for (int i = 0; i < 8; i++) push_word(32'd1 << i);
    expect_word(32'd1);
    tick(4);
    chk("ed_slice1_valid", 32'(m_valid), 1);
    chk("ed_slice1_data", 32'(m_data), 0);
    enable = 1'b0;
    tick(3);
    chk("ed_busy", 32'(busy), 0);
    chk("ed_valid", 32'(m_valid), 0);
    tick(3);
    chk("ed_idle", 32'(busy), 0);
    chk("ed_pops", pops, 6);
    chk("ed_count", 32'(word_count), 6);
    chk("ed_left", exp_q.size(), 0);
    enable = 1'b1;
    for (int i = 1; i < 8; i++) expect_word(32'd1 << i);
    wait_drain("ed");
    chk("ed_count_all", 32'(word_count), 13);
    chk("ed_pops_all", pops, 13);

    push_word(32'hA1B2C3D4);
    push_word(32'h0DDC0FFE);
    exp_q.push_back(9'h0D4);
    exp_q.push_back(9'h0C3);
    tick(5);
    chk("rm_slice2", 32'(m_data), 32'hB2);
    rst = 1'b1;
    tick();
    chk("rm_rd_en", 32'(fifo_rd_en), 0);
    chk("rm_cs", 32'(fifo_cs), 0);
    chk("rm_valid", 32'(m_valid), 0);
    chk("rm_data", 32'(m_data), 0);
    chk("rm_last", 32'(m_last), 0);
    chk("rm_busy", 32'(busy), 0);
    chk("rm_count", 32'(word_count), 0);
    rst = 1'b0;
    expect_word(32'h0DDC0FFE);
    wait_drain("rm");
    chk("rm_count_after", 32'(word_count), 1);
    chk("rm_pops", pops, 15);
    chk("underflow", 32'(uflow), 0);
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_drain_unpacker.md
Name: fifo_drain_unpacker

Overview:
Downstream consumer of the team's synchronous FIFO (cs/rd_en/dout/empty interface). It pops DATA_WIDTH words whenever the FIFO is non-empty and enabled. Each word is unpacked into DATA_WIDTH/OUT_WIDTH narrower slices, LSB slice first, on a valid/ready output stream. The block feeds byte-oriented sinks (serial TX, narrow bus bridge) from the wide FIFO.

Parameters:
DATA_WIDTH, 32, FIFO word width; must be an integer multiple of OUT_WIDTH, otherwise elaboration error
OUT_WIDTH, 8, output slice width
COUNT_WIDTH, 16, width of the completed-word counter

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
enable  input  1  permit new FIFO pops; sampled each cycle
fifo_empty  input  1  FIFO empty flag
fifo_dout  input  DATA_WIDTH  FIFO read data; valid the cycle after the pop edge
fifo_cs  output  1  FIFO chip select; driven high only together with fifo_rd_en
fifo_rd_en  output  1  FIFO pop request, registered, one-cycle pulse per word
m_data  output  OUT_WIDTH  current slice
m_valid  output  1  slice valid
m_ready  input  1  sink accepts slice
m_last  output  1  high with the final slice of a word
busy  output  1  high whenever state != IDLE
word_count  output  COUNT_WIDTH  words fully transmitted since reset; wraps

Behaviour:
- SLICES = DATA_WIDTH/OUT_WIDTH. The slice index counter is clog2(SLICES) bits, minimum 1.
- Reset (rst high at an edge): state IDLE. All outputs 0, including fifo_cs, fifo_rd_en, m_valid, m_last, m_data, busy and word_count. The shift register and slice index are cleared. Reset overrides every other input.
- FSM states: IDLE, RD, WAIT, SEND.
- IDLE: at an edge with enable=1 and fifo_empty=0, go to RD. Otherwise stay in IDLE.
- RD: fifo_rd_en=1 and fifo_cs=1 for exactly this one cycle. Next state is WAIT.
- WAIT: fifo_rd_en=0. At the end of this cycle, capture fifo_dout into the shift register, set m_valid=1, set slice index to 0, and go to SEND.
- SEND: m_data equals the shift register's low OUT_WIDTH bits. m_last=1 when slice index = SLICES-1.
  - On an edge with m_valid && m_ready: shift the register right by OUT_WIDTH and increment the slice index.
  - If the accepted slice was the last one: word_count increments, m_valid and m_last go to 0, and the next state is RD if enable=1 and fifo_empty=0 at that edge, otherwise IDLE.
- Output stability: while m_valid=1 and m_ready=0, m_data, m_last and m_valid hold unchanged. m_valid never drops without a handshake except on reset.
- Latency: the edge that samples enable && !fifo_empty in IDLE is E0. rd_en is high during cycle E0..E1. m_valid rises at E2.
- Throughput: with m_ready held high, a word occupies SLICES+2 cycles and back-to-back words need no IDLE cycle. For default parameters this is 6 cycles per word.
- Pop rules:
  - fifo_rd_en is never asserted when fifo_empty was sampled 1 at the deciding edge.
  - Never more than one pop per word.
  - No pop while a word is still being sent. This guarantees fifo_empty reflects the previous pop before it is sampled.
- enable deasserted mid-word: the current word completes in full, then the block returns to IDLE. enable never truncates a word.
- Reset mid-word: the in-flight word is discarded and no extra rd_en is issued. That word is lost, which is acceptable.
- word_count wraps from 2^COUNT_WIDTH-1 to 0.

Test Plan:
- Reset check: hold rst=1 for 3 cycles with enable=1 and fifo_empty=0 -> all outputs stay 0 and no rd_en pulse.
- Single word: FIFO holds 0x44332211, enable=1, m_ready=1 -> exactly one rd_en pulse; m_data sequence 0x11,0x22,0x33,0x44; m_last only with 0x44; m_valid rises 2 cycles after the deciding edge; word_count=1; busy low after 6 cycles.
- Backpressure: same word with m_ready=0 for 3 cycles while 0x22 is presented -> m_data holds 0x22 and m_valid stays 1; sequence is unchanged with no drop or duplicate.
- Back-to-back: write 1, 10, 100 into the FIFO, m_ready=1 -> bytes 01 00 00 00 0A 00 00 00 64 00 00 00; three rd_en pulses spaced 6 cycles apart; word_count=3; fifo_empty=1 afterwards and no fourth rd_en.
- Enable drop: FIFO holds 8 words (2**i), enable dropped during slice 1 of word 0 -> word 0 (0x00000001) completes and the block returns to IDLE; re-enabling resumes with word 1 = 0x00000002.
- Reset mid-word: rst pulsed during slice 2 -> outputs 0 on the next cycle, word_count=0, no rd_en in that cycle; after release the next FIFO word streams normally.
